// File: rtl/dispatch_unit.sv
// dispatch_unit: RV32IM decode, register renaming and dispatch to the issue queues.
// Operands are resolved from the regfile/RST or forwarded from the CDB in the same cycle.
module dispatch_decoder (
   input  logic [31:0] instr_i,
   output logic        int_enabler,
   output logic        mul_enabler,
   output logic        div_enabler,
   output logic        ldst_enabler,
   output logic [3:0]  op_o,
   output logic [31:0] imm_o,
   output logic        need_tag_o,
   output logic [1:0]  rs1_sel_o,
   output logic [1:0]  rs2_sel_o,
   output logic        jal_o,
   output logic        jalr_o,
   output logic        br_o
);
   logic [2:0] f3;
   logic [6:0] f7;
   logic [3:0] alu_op;
   logic [3:0] br_op;
   assign f3 = instr_i[14:12];
   assign f7 = instr_i[31:25];
   // bit 5 of the major opcode separates register ADD/SUB from ADDI
   assign alu_op = f3 == 3'd0 ? {3'd0, instr_i[5] & f7[5]} : f3 == 3'd1 ? 4'd5 :
                   f3 == 3'd2 ? 4'd8 : f3 == 3'd3 ? 4'd9 : f3 == 3'd4 ? 4'd4 :
                   f3 == 3'd5 ? (f7[5] ? 4'd7 : 4'd6) : f3 == 3'd6 ? 4'd3 : 4'd2;
   assign br_op = f3[2] ? 4'd8 + {1'b0, f3} : 4'd10 + {3'd0, f3[0]};
   always_comb begin
      int_enabler  = 1'b0;
      mul_enabler  = 1'b0;
      div_enabler  = 1'b0;
      ldst_enabler = 1'b0;
      op_o         = 4'd0;
      imm_o        = {{20{instr_i[31]}}, instr_i[31:20]};
      need_tag_o   = 1'b0;
      rs1_sel_o    = 2'd0;
      rs2_sel_o    = 2'd0;
      jal_o        = 1'b0;
      jalr_o       = 1'b0;
      br_o         = 1'b0;
      case (instr_i[6:0])
         7'b0110011: begin
            if (f7 == 7'b0000001) begin
               mul_enabler = ~f3[2];
               div_enabler = f3[2];
               op_o        = {2'd0, f3[1:0]};
               need_tag_o  = 1'b1;
            end else if (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
               int_enabler = 1'b1;
               op_o        = alu_op;
               need_tag_o  = 1'b1;
            end
         end
         7'b0010011: begin
            int_enabler = 1'b1;
            op_o        = alu_op;
            rs2_sel_o   = 2'd1;
            need_tag_o  = 1'b1;
         end
         7'b0000011: if (f3 == 3'd2) begin
            ldst_enabler = 1'b1;
            rs2_sel_o    = 2'd1;
            need_tag_o   = 1'b1;
         end
         7'b0100011: if (f3 == 3'd2) begin
            ldst_enabler = 1'b1;
            op_o         = 4'd1;
         end
         7'b0110111, 7'b0010111: begin
            int_enabler = 1'b1;
            imm_o       = {instr_i[31:12], 12'd0};
            rs1_sel_o   = instr_i[5] ? 2'd1 : 2'd2;
            rs2_sel_o   = 2'd1;
            need_tag_o  = 1'b1;
         end
         7'b1101111: begin
            int_enabler = 1'b1;
            imm_o       = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            rs1_sel_o   = 2'd2;
            rs2_sel_o   = 2'd2;
            need_tag_o  = 1'b1;
            jal_o       = 1'b1;
         end
         7'b1100111: if (f3 == 3'd0) begin
            int_enabler = 1'b1;
            rs1_sel_o   = 2'd2;
            rs2_sel_o   = 2'd2;
            need_tag_o  = 1'b1;
            jalr_o      = 1'b1;
         end
         7'b1100011: if (f3[2:1] != 2'b01) begin
            int_enabler = 1'b1;
            op_o        = br_op;
            imm_o       = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            br_o        = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

module dispatch_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int REGISTER_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           Instruction,
   input  logic [DATA_WIDTH-1:0] PC_out,
   input  logic [5:0]            CDB_tag,
   input  logic                  CDB_valid,
   input  logic [DATA_WIDTH-1:0] CDB_data,
   input  logic                  CDB_branch,
   input  logic                  CDB_branch_taken,
   input  logic                  issueque_full_integer,
   input  logic                  issueque_full_ld_st,
   input  logic                  issueque_full_mul,
   input  logic                  issueque_full_div,
   output logic                  Read_enable,
   output logic                  jump_branch_valid,
   output logic [DATA_WIDTH-1:0] jump_branch_address,
   output logic [3:0]            dispatch_opcode,
   output logic                  dispatch_en_integer,
   output logic                  dispatch_en_ld_st,
   output logic                  dispatch_en_mul,
   output logic                  dispatch_en_div,
   output logic [5:0]            dispatch_rd_tag,
   output logic [DATA_WIDTH-1:0] dispatch_rs1_data,
   output logic [5:0]            dispatch_rs1_tag,
   output logic                  dispatch_rs1_valid,
   output logic [DATA_WIDTH-1:0] dispatch_rs2_data,
   output logic [5:0]            dispatch_rs2_tag,
   output logic                  dispatch_rs2_valid
);
   localparam int TW = REGISTER_WIDTH - 1;
   logic [DATA_WIDTH-1:0] rf_q [32];
   logic [31:0]           rst_v_q;
   logic [TW-1:0]         rst_t_q [32];
   logic [TW-1:0]         fifo_q [64];
   logic [5:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [6:0]            cnt_q, cnt_d;
   logic                  branch_q, branch_d;
   logic [DATA_WIDTH-1:0] target_q, target_d;
   logic                  int_en, mul_en, div_en, ls_en, need_tag, jal, jalr, br;
   logic [3:0]            op;
   logic [31:0]           imm;
   logic [1:0]            rs1_sel, rs2_sel;
   logic [4:0]            rs1, rs2, rd;
   logic                  fwd1, fwd2, v1, v2, full, stall, valid_ins, disp, pop;
   logic [DATA_WIDTH-1:0] d1, d2;

   dispatch_decoder Decoder (
      .instr_i(Instruction), .int_enabler(int_en), .mul_enabler(mul_en),
      .div_enabler(div_en), .ldst_enabler(ls_en), .op_o(op), .imm_o(imm),
      .need_tag_o(need_tag), .rs1_sel_o(rs1_sel), .rs2_sel_o(rs2_sel),
      .jal_o(jal), .jalr_o(jalr), .br_o(br)
   );

   assign rs1 = Instruction[19:15];
   assign rs2 = Instruction[24:20];
   assign rd  = Instruction[11:7];
   // x0 is never renamed or written, so it always resolves to valid data 0
   assign fwd1 = ~rst_v_q[rs1] & CDB_valid & (CDB_tag == rst_t_q[rs1]);
   assign fwd2 = ~rst_v_q[rs2] & CDB_valid & (CDB_tag == rst_t_q[rs2]);
   assign v1 = rst_v_q[rs1] | fwd1;
   assign v2 = rst_v_q[rs2] | fwd2;
   assign d1 = rst_v_q[rs1] ? rf_q[rs1] : fwd1 ? CDB_data : '0;
   assign d2 = rst_v_q[rs2] ? rf_q[rs2] : fwd2 ? CDB_data : '0;

   assign full = (int_en & issueque_full_integer) | (ls_en & issueque_full_ld_st) |
                 (mul_en & issueque_full_mul) | (div_en & issueque_full_div);
   assign stall = branch_q | full | (need_tag & cnt_q == 7'd0) | (jalr & ~v1);
   assign valid_ins = int_en | mul_en | div_en | ls_en;
   assign disp = valid_ins & ~stall;
   assign pop = disp & need_tag;

   assign Read_enable         = ~reset | (valid_ins ? disp : ~branch_q);
   assign dispatch_en_integer = reset & disp & int_en;
   assign dispatch_en_ld_st   = reset & disp & ls_en;
   assign dispatch_en_mul     = reset & disp & mul_en;
   assign dispatch_en_div     = reset & disp & div_en;
   assign jump_branch_valid   = reset & ((disp & (jal | jalr)) | (branch_q & CDB_branch & CDB_branch_taken));
   assign jump_branch_address = ~reset ? '0 : branch_q ? target_q :
                                jalr ? (d1 + imm) & ~32'd1 : PC_out + imm;
   assign dispatch_opcode     = reset ? op : 4'd0;
   assign dispatch_rd_tag     = reset ? fifo_q[rd_ptr_q] : '0;
   assign dispatch_rs1_data   = ~reset || rs1_sel == 2'd1 ? '0 : rs1_sel == 2'd2 ? PC_out : d1;
   assign dispatch_rs1_tag    = reset && rs1_sel == 2'd0 ? rst_t_q[rs1] : '0;
   assign dispatch_rs1_valid  = reset & (rs1_sel != 2'd0 | v1);
   assign dispatch_rs2_data   = ~reset ? '0 : rs2_sel == 2'd1 ? imm : rs2_sel == 2'd2 ? 32'd4 : d2;
   assign dispatch_rs2_tag    = reset && rs2_sel == 2'd0 ? rst_t_q[rs2] : '0;
   assign dispatch_rs2_valid  = reset & (rs2_sel != 2'd0 | v2);

   always_comb begin
      rd_ptr_d = rd_ptr_q + 6'(pop);
      wr_ptr_d = wr_ptr_q + 6'(CDB_valid);
      cnt_d    = cnt_q + 7'(CDB_valid) - 7'(pop);
      branch_d = disp & br ? 1'b1 : branch_q & CDB_branch ? 1'b0 : branch_q;
      target_d = disp & br ? PC_out + imm : target_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i]    <= '0;
            rst_t_q[i] <= '0;
         end
         for (int i = 0; i < 64; i++) fifo_q[i] <= TW'(i);
         rst_v_q  <= '1;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= 7'd64;
         branch_q <= 1'b0;
         target_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         branch_q <= branch_d;
         target_q <= target_d;
         if (CDB_valid) fifo_q[wr_ptr_q] <= CDB_tag;
         for (int i = 1; i < 32; i++)
            if (CDB_valid && !rst_v_q[i] && rst_t_q[i] == CDB_tag) begin
               rst_v_q[i] <= 1'b1;
               rf_q[i]    <= CDB_data;
            end
         // a new rename of rd overrides a same-cycle CDB wakeup of that entry
         if (pop && rd != 5'd0) begin
            rst_v_q[rd] <= 1'b0;
            rst_t_q[rd] <= fifo_q[rd_ptr_q];
         end
      end
   end
endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: directed checks of decode, renaming, stalls, branches and jumps.
module tb_dispatch_unit;
   logic        clk = 1'b0, reset = 1'b0;
   logic [31:0] Instruction = '0, PC_out = '0, CDB_data = '0;
   logic [5:0]  CDB_tag = '0;
   logic        CDB_valid = 1'b0, CDB_branch = 1'b0, CDB_branch_taken = 1'b0;
   logic        fi = 1'b0, fl = 1'b0, fm = 1'b0, fd = 1'b0;
   logic        Read_enable, jump_branch_valid;
   logic [31:0] jump_branch_address, dispatch_rs1_data, dispatch_rs2_data;
   logic [3:0]  dispatch_opcode;
   logic        en_int, en_ls, en_mul, en_div, dispatch_rs1_valid, dispatch_rs2_valid;
   logic [5:0]  dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
   int checks = 0, errors = 0;

   dispatch_unit dut (
      .clk(clk), .reset(reset), .Instruction(Instruction), .PC_out(PC_out),
      .CDB_tag(CDB_tag), .CDB_valid(CDB_valid), .CDB_data(CDB_data),
      .CDB_branch(CDB_branch), .CDB_branch_taken(CDB_branch_taken),
      .issueque_full_integer(fi), .issueque_full_ld_st(fl),
      .issueque_full_mul(fm), .issueque_full_div(fd),
      .Read_enable(Read_enable), .jump_branch_valid(jump_branch_valid),
      .jump_branch_address(jump_branch_address), .dispatch_opcode(dispatch_opcode),
      .dispatch_en_integer(en_int), .dispatch_en_ld_st(en_ls),
      .dispatch_en_mul(en_mul), .dispatch_en_div(en_div),
      .dispatch_rd_tag(dispatch_rd_tag),
      .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag),
      .dispatch_rs1_valid(dispatch_rs1_valid),
      .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag),
      .dispatch_rs2_valid(dispatch_rs2_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] ins, input logic [31:0] pc);
      Instruction = ins;
      PC_out = pc;
      #1;
   endtask

   initial begin
      put(32'h00500093, 32'h0);
      chk("rst_re", Read_enable, 1);
      chk("rst_en_int", en_int, 0);
      chk("rst_jbv", jump_branch_valid, 0);
      chk("rst_rs2_data", dispatch_rs2_data, 0);
      tick();
      reset = 1'b1;
      put(32'h00500093, 32'h0);                   // ADDI x1,x0,5
      chk("addi_en", en_int, 1);
      chk("addi_op", dispatch_opcode, 0);
      chk("addi_tag", dispatch_rd_tag, 0);
      chk("addi_rs1", dispatch_rs1_data, 0);
      chk("addi_rs1v", dispatch_rs1_valid, 1);
      chk("addi_rs2", dispatch_rs2_data, 5);
      chk("addi_rs2v", dispatch_rs2_valid, 1);
      chk("addi_re", Read_enable, 1);
      tick();
      put(32'h00108133, 32'h4);                   // ADD x2,x1,x1
      chk("add_tag", dispatch_rd_tag, 1);
      chk("add_rs1t", dispatch_rs1_tag, 0);
      chk("add_rs2t", dispatch_rs2_tag, 0);
      chk("add_rs1v", dispatch_rs1_valid, 0);
      chk("add_rs2v", dispatch_rs2_valid, 0);
      tick();
      CDB_valid = 1'b1; CDB_tag = 6'd0; CDB_data = 32'd7;
      put(32'h000081B3, 32'h8);                   // ADD x3,x1,x0 with CDB forward
      chk("fwd_rs1", dispatch_rs1_data, 7);
      chk("fwd_rs1v", dispatch_rs1_valid, 1);
      chk("fwd_rs2v", dispatch_rs2_valid, 1);
      chk("fwd_tag", dispatch_rd_tag, 2);
      tick();
      CDB_valid = 1'b0;
      put(32'h40208233, 32'hC);                   // SUB x4,x1,x2
      chk("sub_op", dispatch_opcode, 1);
      chk("sub_rs1", dispatch_rs1_data, 7);
      chk("sub_rs1v", dispatch_rs1_valid, 1);
      chk("sub_rs2t", dispatch_rs2_tag, 1);
      chk("sub_rs2v", dispatch_rs2_valid, 0);
      chk("sub_tag", dispatch_rd_tag, 3);
      tick();
      fi = 1'b1;
      put(32'h00100293, 32'h10);                  // ADDI x5,x0,1 vs full queue
      for (int c = 0; c < 2; c++) begin
         chk("full_re", Read_enable, 0);
         chk("full_en", en_int, 0);
         tick();
      end
      fi = 1'b0;
      #1;
      chk("rel_en", en_int, 1);
      chk("rel_tag", dispatch_rd_tag, 4);
      tick();
      put(32'h02108333, 32'h14);                  // MUL x6,x1,x1
      chk("mul_en", en_mul, 1);
      chk("mul_int", en_int, 0);
      chk("mul_op", dispatch_opcode, 0);
      chk("mul_tag", dispatch_rd_tag, 5);
      tick();
      put(32'h0210D3B3, 32'h18);                  // DIVU x7,x1,x1
      chk("divu_en", en_div, 1);
      chk("divu_op", dispatch_opcode, 1);
      chk("divu_tag", dispatch_rd_tag, 6);
      tick();
      put(32'h00102223, 32'h1C);                  // SW x1,4(x0)
      chk("sw_en", en_ls, 1);
      chk("sw_op", dispatch_opcode, 1);
      chk("sw_rs1", dispatch_rs1_data, 0);
      chk("sw_rs2", dispatch_rs2_data, 7);
      chk("sw_rs2v", dispatch_rs2_valid, 1);
      tick();
      put(32'h00C0A403, 32'h20);                  // LW x8,12(x1)
      chk("lw_en", en_ls, 1);
      chk("lw_op", dispatch_opcode, 0);
      chk("lw_rs1", dispatch_rs1_data, 7);
      chk("lw_rs2", dispatch_rs2_data, 12);
      chk("lw_tag", dispatch_rd_tag, 7);
      tick();
      put(32'h00108463, 32'h10);                  // BEQ x1,x1,+8
      chk("beq_en", en_int, 1);
      chk("beq_op", dispatch_opcode, 10);
      chk("beq_re", Read_enable, 1);
      tick();
      put(32'h00300493, 32'h14);                  // ADDI x9,x0,3 held by branch
      chk("bstall_re", Read_enable, 0);
      chk("bstall_en", en_int, 0);
      tick();
      CDB_branch = 1'b1; CDB_branch_taken = 1'b1;
      #1;
      chk("btaken_jbv", jump_branch_valid, 1);
      chk("btaken_addr", jump_branch_address, 32'h18);
      chk("btaken_re", Read_enable, 0);
      tick();
      CDB_branch = 1'b0; CDB_branch_taken = 1'b0;
      put(32'h00300493, 32'h18);
      chk("bdone_en", en_int, 1);
      chk("bdone_tag", dispatch_rd_tag, 8);
      chk("bdone_jbv", jump_branch_valid, 0);
      tick();
      put(32'h0000000F, 32'h1C);                  // FENCE: unsupported
      chk("nop_re", Read_enable, 1);
      chk("nop_en", {en_int, en_ls, en_mul, en_div}, 0);
      tick();
      put(32'h020000EF, 32'h100);                 // JAL x1,+0x20
      chk("jal_jbv", jump_branch_valid, 1);
      chk("jal_addr", jump_branch_address, 32'h120);
      chk("jal_rs1", dispatch_rs1_data, 32'h100);
      chk("jal_rs2", dispatch_rs2_data, 4);
      chk("jal_tag", dispatch_rd_tag, 9);
      tick();
      put(32'h00008067, 32'h120);                 // JALR x0,0(x1), x1 busy
      chk("jalr_stall_re", Read_enable, 0);
      chk("jalr_stall_jbv", jump_branch_valid, 0);
      tick();
      CDB_valid = 1'b1; CDB_tag = 6'd9; CDB_data = 32'h205;
      #1;
      chk("jalr_jbv", jump_branch_valid, 1);
      chk("jalr_addr", jump_branch_address, 32'h204);
      chk("jalr_re", Read_enable, 1);
      tick();
      CDB_valid = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      put(32'h00100293, 32'h0);                   // ADDI x5 x64 drains all tags
      for (int i = 0; i < 64; i++) begin
         if (i == 63) chk("drain_tag", dispatch_rd_tag, 63);
         tick();
      end
      put(32'h02108333, 32'h0);                   // MUL with no free tag
      chk("empty_re", Read_enable, 0);
      chk("empty_en", en_mul, 0);
      tick();
      CDB_valid = 1'b1; CDB_tag = 6'd5; CDB_data = 32'h0;
      #1;
      chk("empty_push_en", en_mul, 0);
      tick();
      CDB_valid = 1'b0;
      #1;
      chk("ret_en", en_mul, 1);
      chk("ret_tag", dispatch_rd_tag, 5);
      tick();
      put(32'h00108463, 32'h10);                  // BEQ, then reset mid-stall
      tick();
      put(32'h00108133, 32'h14);
      chk("mid_re", Read_enable, 0);
      reset = 1'b0;
      #1;
      chk("async_re", Read_enable, 1);
      chk("async_en", en_int, 0);
      reset = 1'b1;
      #1;
      chk("post_en", en_int, 1);
      chk("post_rs1v", dispatch_rs1_valid, 1);
      chk("post_rs1", dispatch_rs1_data, 0);
      chk("post_tag", dispatch_rd_tag, 0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
